// File: rtl/arithmetic_unit.sv
// Registered 32-bit arithmetic unit: transfer/increment/add/subtract/decrement
// through B-input select logic and a full-adder ripple chain, with carry and overflow flags.
module arithmetic_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  S,
    input  logic        Cin,
    output logic [31:0] arOut,
    output logic        Cout,
    output logic        V
);

    localparam int unsigned W = 32;

    logic [W-1:0] y;
    logic [W-1:0] sum;
    logic         c31;
    logic         c32;

    // B-input logic: selects the second adder operand
    always_comb begin
        y = '0;
        case (S)
            2'b00: y = '0;
            2'b01: y = B;
            2'b10: y = ~B;
            2'b11: y = '1;
            default: y = '0;
        endcase
    end

    // Ripple-carry adder; c31 is kept for the overflow flag
    always_comb begin
        logic carry;
        carry = Cin;
        sum   = '0;
        c31   = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            if (i == int'(W) - 1) begin
                c31 = carry;
            end
            sum[i] = A[i] ^ y[i] ^ carry;
            carry  = (A[i] & y[i]) | (carry & (A[i] ^ y[i]));
        end
        c32 = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arOut <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
        end else begin
            arOut <= sum;
            Cout  <= c32;
            V     <= c31 ^ c32;
        end
    end

endmodule

// File: tb/tb_arithmetic_unit.sv
// Scoreboard bench for arithmetic_unit: driver pushes hand-computed expectations,
// monitor pops and compares one cycle after each issued operation.
module tb_arithmetic_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B;
    logic [1:0]  S;
    logic        Cin;
    logic [31:0] arOut;
    logic        Cout, V;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic issue   = 1'b0;

    arithmetic_unit dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .S(S), .Cin(Cin),
        .arOut(arOut), .Cout(Cout), .V(V)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] s, input logic ci,
                         input logic [31:0] er, input logic ec, input logic ev,
                         input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; A = a; B = b; S = s; Cin = ci;
        issue = 1'b1;
        e.res = er; e.c = ec; e.v = ev; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: each edge that sampled an issued op produces one checked result
    initial begin
        exp_t e;
        logic pend;
        forever begin
            @(posedge clk);
            pend = issue;
            #1;
            if (pend) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow: result with no expectation");
                end else begin
                    e = exp_q.pop_front();
                    if (arOut !== e.res || Cout !== e.c || V !== e.v) begin
                        n_fail++;
                        $display("FAIL %s: got arOut=%h Cout=%b V=%b, want arOut=%h Cout=%b V=%b",
                                 e.name, arOut, Cout, V, e.res, e.c, e.v);
                    end
                end
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1; A = '0; B = '0; S = 2'b00; Cin = 1'b0;
        repeat (2) @(posedge clk);

        drive(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1, 32'h0, 0, 0, "reset_1");
        drive(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1, 32'h0, 0, 0, "reset_2");
        drive(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1, 32'hFFFFFFFF, 1, 0, "reset_release");

        drive(0, 32'h1, 32'h0, 2'b00, 0, 32'h1, 0, 0, "transfer");
        drive(0, 32'h1, 32'h0, 2'b00, 1, 32'h2, 0, 0, "increment");
        drive(0, 32'h4, 32'h1, 2'b01, 0, 32'h5, 0, 0, "add");
        drive(0, 32'h1, 32'h1, 2'b10, 0, 32'hFFFFFFFF, 0, 0, "a_plus_not_b");
        drive(0, 32'h1, 32'h0, 2'b11, 0, 32'h0, 1, 0, "decrement");
        drive(0, 32'h1, 32'h2, 2'b11, 1, 32'h1, 1, 0, "transfer_s11");
        drive(0, 32'h7FFFFFFF, 32'h1, 2'b01, 0, 32'h80000000, 0, 1, "add_ovf_pos");
        drive(0, 32'h80000002, 32'h8000000F, 2'b01, 0, 32'h00000011, 1, 1, "add_ovf_neg");
        drive(0, 32'hEFFFFFFF, 32'h7FFFFFFF, 2'b10, 1, 32'h70000000, 1, 1, "sub_ovf_neg");
        drive(0, 32'h0000000F, 32'h8000000F, 2'b10, 1, 32'h80000000, 0, 1, "sub_ovf_pos");

        // Back-to-back across all select codes
        drive(0, 32'h12345678, 32'h0, 2'b00, 1, 32'h12345679, 0, 0, "b2b_inc");
        drive(0, 32'hFFFFFFFF, 32'h1, 2'b01, 0, 32'h0, 1, 0, "b2b_add_wrap");
        drive(0, 32'h5, 32'h3, 2'b10, 1, 32'h2, 1, 0, "b2b_sub");
        drive(0, 32'h0, 32'h0, 2'b11, 0, 32'hFFFFFFFF, 0, 0, "b2b_dec_zero");
        drive(0, 32'h80000000, 32'h0, 2'b11, 0, 32'h7FFFFFFF, 1, 1, "b2b_dec_ovf");
        drive(0, 32'h7FFFFFFF, 32'h0, 2'b00, 1, 32'h80000000, 0, 1, "b2b_inc_ovf");

        // Reset mid-stream discards the op on the reset edge
        drive(1, 32'h00000010, 32'h00000020, 2'b01, 0, 32'h0, 0, 0, "midstream_reset");
        drive(0, 32'h00000010, 32'h00000020, 2'b01, 0, 32'h30, 0, 0, "after_midstream_reset");

        @(negedge clk);
        issue = 1'b0;

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
